scie_cmd_sequencer: RTL and testbench

SCIE_CMD_SEQUENCER -- requirements
Module: scie_cmd_sequencer

---
 rtl/scie_pkg.sv | 41 ++++
 rtl/scie_cmd_fifo.sv | 54 +++++
 rtl/scie_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_scie_cmd_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scie_pkg.sv
// Shared opcodes, command/state enums and the FIFO entry layout for the
// SCIE command sequencer.
package scie_pkg;

   localparam logic [6:0] OPC_LOAD_COEF = 7'h0B;
   localparam logic [6:0] OPC_PUSH      = 7'h2B;
   localparam logic [6:0] OPC_READ      = 7'h5B;

   typedef enum logic [1:0] {
      CMD_LOAD_COEF,
      CMD_PUSH,
      CMD_READ,
      CMD_ILLEGAL
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GAP,
      ST_WAIT_RD,
      ST_RESP
   } state_e;

   typedef struct packed {
      logic [31:0] insn;
      logic [63:0] rs1_real;
      logic [63:0] rs1_imag;
      logic [31:0] rs2;
      logic [4:0]  tag;
   } cmd_entry_t;

   function automatic cmd_e decode_cmd(input logic [6:0] opcode);
      case (opcode)
         OPC_LOAD_COEF: return CMD_LOAD_COEF;
         OPC_PUSH:      return CMD_PUSH;
         OPC_READ:      return CMD_READ;
         default:       return CMD_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/scie_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), wrapping pointers plus an
// occupancy counter. No bypass path; callers never push when full or pop when empty.
module scie_cmd_fifo
   import scie_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  cmd_entry_t data_in,
   input  logic       pop,
   output cmd_entry_t data_out,
   output logic       full,
   output logic       empty
);

   localparam int          AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   cmd_entry_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   // NOTE: the storage array is deliberately not reset; validity is tracked
   // by count alone, so clearing the data would only cost flops and routing.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= data_in;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign data_out = mem[rd_ptr];
   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);

endmodule

// File: rtl/scie_cmd_sequencer.sv
// Queues core commands and issues them one at a time to SCIEPipelined,
// honouring the PUSH gap and a single outstanding READ. Optional perf
// counters are enabled by defining SCIE_SEQ_PERF_EN.
module scie_cmd_sequencer
   import scie_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int READ_LAT = 1,
   parameter int PUSH_GAP = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_insn,
   input  logic [63:0] in_rs1_real,
   input  logic [63:0] in_rs1_imag,
   input  logic [31:0] in_rs2,
   input  logic [4:0]  in_tag,
   output logic        scie_valid,
   output logic [31:0] scie_insn,
   output logic [63:0] scie_rs1_real,
   output logic [63:0] scie_rs1_imag,
   output logic [31:0] scie_rs2,
   input  logic [63:0] scie_rd_real,
   input  logic [63:0] scie_rd_imag,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_real,
   output logic [63:0] resp_imag,
   output logic [4:0]  resp_tag,
   output logic        illegal,
   output logic        busy
`ifdef SCIE_SEQ_PERF_EN
   ,
   output logic [31:0] perf_issued,
   output logic [31:0] perf_stall
`endif
);

   localparam int               CNT_W    = 16;
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((PUSH_GAP > 0) ? PUSH_GAP - 1 : 0);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);

   state_e           state;
   state_e           state_n;
   logic [CNT_W-1:0] cnt;
   cmd_entry_t       in_entry;
   cmd_entry_t       head;
   cmd_e             in_cmd;
   cmd_e             head_cmd;
   logic             full;
   logic             empty;
   logic             accept;
   logic             push;
   logic             pop;
   logic             capture;
   logic             illegal_q;
   logic [4:0]       cur_tag;
   logic [63:0]      resp_real_q;
   logic [63:0]      resp_imag_q;
   logic [4:0]       resp_tag_q;

   assign in_cmd   = decode_cmd(in_insn[6:0]);
   assign in_ready = !full && !reset;
   assign accept   = in_valid && in_ready;
   assign push     = accept && (in_cmd != CMD_ILLEGAL);
   assign in_entry = '{insn: in_insn, rs1_real: in_rs1_real, rs1_imag: in_rs1_imag,
                       rs2: in_rs2, tag: in_tag};

   scie_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .data_in  (in_entry),
      .pop      (pop),
      .data_out (head),
      .full     (full),
      .empty    (empty)
   );

   assign head_cmd = decode_cmd(head.insn[6:0]);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_n = state;
      pop     = 1'b0;
      capture = 1'b0;
      case (state)
         ST_IDLE:    if (!empty) state_n = ST_ISSUE;
         ST_ISSUE: begin
            pop = 1'b1;
            case (head_cmd)
               CMD_PUSH: state_n = (PUSH_GAP == 0) ? ST_IDLE : ST_GAP;
               CMD_READ: state_n = ST_WAIT_RD;
               default:  state_n = ST_IDLE;
            endcase
         end
         ST_GAP:     if (cnt == GAP_LAST) state_n = ST_IDLE;
         ST_WAIT_RD: begin
            if (cnt == RD_LAST) begin
               capture = 1'b1;
               state_n = ST_RESP;
            end
         end
         ST_RESP:    if (resp_ready) state_n = ST_IDLE;
         default:    state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         illegal_q   <= 1'b0;
         cur_tag     <= '0;
         resp_real_q <= '0;
         resp_imag_q <= '0;
         resp_tag_q  <= '0;
      end else begin
         state     <= state_n;
         illegal_q <= accept && (in_cmd == CMD_ILLEGAL);
         // The counter only runs while dwelling in a timed state.
         if ((state_n == state) && (state == ST_GAP || state == ST_WAIT_RD))
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
         if (pop) cur_tag <= head.tag;
         if (capture) begin
            resp_real_q <= scie_rd_real;
            resp_imag_q <= scie_rd_imag;
            resp_tag_q  <= cur_tag;
         end
      end
   end

   // Outputs are masked by reset so they read zero throughout the reset cycle.
   assign scie_valid    = (state == ST_ISSUE) && !reset;
   assign scie_insn     = scie_valid ? head.insn     : '0;
   assign scie_rs1_real = scie_valid ? head.rs1_real : '0;
   assign scie_rs1_imag = scie_valid ? head.rs1_imag : '0;
   assign scie_rs2      = scie_valid ? head.rs2      : '0;

   assign resp_valid = (state == ST_RESP) && !reset;
   assign resp_real  = resp_valid ? resp_real_q : '0;
   assign resp_imag  = resp_valid ? resp_imag_q : '0;
   assign resp_tag   = resp_valid ? resp_tag_q  : '0;

   assign illegal = illegal_q && !reset;
   assign busy    = (!empty || state != ST_IDLE) && !reset;

`ifdef SCIE_SEQ_PERF_EN
   logic [31:0] issued_q;
   logic [31:0] stall_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         issued_q <= '0;
         stall_q  <= '0;
      end else begin
         if (state == ST_ISSUE && issued_q != '1) issued_q <= issued_q + 1'b1;
         if (in_valid && !in_ready && stall_q != '1) stall_q <= stall_q + 1'b1;
      end
   end

   assign perf_issued = reset ? '0 : issued_q;
   assign perf_stall  = reset ? '0 : stall_q;
`endif

endmodule

// File: tb/tb_scie_cmd_sequencer.sv
// Directed bench for scie_cmd_sequencer with a behavioural SCIEPipelined
// (5-tap complex Q32 FIR) behind it. Define SCIE_SEQ_PERF_EN to add perf tests.
`timescale 1ns/1ps
module tb_scie_cmd_sequencer;

   localparam int DEPTH    = 4;
   localparam int READ_LAT = 1;
   localparam int PUSH_GAP = 1;

   localparam logic [31:0] I_LOAD = 32'h0000_000B;
   localparam logic [31:0] I_PUSH = 32'h0000_002B;
   localparam logic [31:0] I_READ = 32'h0000_005B;

   localparam logic signed [63:0] COEF_RE [5] = '{64'sd203841466979, -64'sd100788414711,
      64'sd40916663891, -64'sd179196331571, -64'sd42177684242};
   localparam logic signed [63:0] COEF_IM [5] = '{64'sd20913234674, 64'sd56876281971,
      64'sd144455627928, 64'sd154665368591, 64'sd83188099625};

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_insn = '0;
   logic [63:0] in_rs1_real = '0;
   logic [63:0] in_rs1_imag = '0;
   logic [31:0] in_rs2 = '0;
   logic [4:0]  in_tag = '0;
   logic        scie_valid;
   logic [31:0] scie_insn;
   logic [63:0] scie_rs1_real;
   logic [63:0] scie_rs1_imag;
   logic [31:0] scie_rs2;
   logic signed [63:0] scie_rd_real;
   logic signed [63:0] scie_rd_imag;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_real;
   logic [63:0] resp_imag;
   logic [4:0]  resp_tag;
   logic        illegal;
   logic        busy;
`ifdef SCIE_SEQ_PERF_EN
   logic [31:0] perf_issued;
   logic [31:0] perf_stall;
`endif

   int checks = 0;
   int passes = 0;

   always #5 clock = ~clock;

   scie_cmd_sequencer #(.DEPTH(DEPTH), .READ_LAT(READ_LAT), .PUSH_GAP(PUSH_GAP)) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_insn       (in_insn),
      .in_rs1_real   (in_rs1_real),
      .in_rs1_imag   (in_rs1_imag),
      .in_rs2        (in_rs2),
      .in_tag        (in_tag),
      .scie_valid    (scie_valid),
      .scie_insn     (scie_insn),
      .scie_rs1_real (scie_rs1_real),
      .scie_rs1_imag (scie_rs1_imag),
      .scie_rs2      (scie_rs2),
      .scie_rd_real  (scie_rd_real),
      .scie_rd_imag  (scie_rd_imag),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_real     (resp_real),
      .resp_imag     (resp_imag),
      .resp_tag      (resp_tag),
      .illegal       (illegal),
      .busy          (busy)
`ifdef SCIE_SEQ_PERF_EN
      ,
      .perf_issued   (perf_issued),
      .perf_stall    (perf_stall)
`endif
   );

   // SCIEPipelined model: coefficient bank, sample delay line, Q32 result
   // registered one cycle after the READ issue.
   logic signed [63:0] c_re [5];
   logic signed [63:0] c_im [5];
   logic signed [63:0] x_re [5];
   logic signed [63:0] x_im [5];

   function automatic logic signed [63:0] fir_out(input bit imag_part);
      logic signed [127:0] acc;
      logic signed [127:0] a, b, c, d;
      acc = '0;
      for (int i = 0; i < 5; i++) begin
         a = c_re[i]; b = c_im[i]; c = x_re[i]; d = x_im[i];
         if (imag_part) acc = acc + a * d + b * c;
         else           acc = acc + a * c - b * d;
      end
      return acc[95:32];
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 5; i++) begin
            c_re[i] <= '0; c_im[i] <= '0; x_re[i] <= '0; x_im[i] <= '0;
         end
         scie_rd_real <= '0;
         scie_rd_imag <= '0;
      end else if (scie_valid) begin
         case (scie_insn[6:0])
            7'h0B: if (scie_rs2 < 5) begin
               c_re[int'(scie_rs2)] <= scie_rs1_real;
               c_im[int'(scie_rs2)] <= scie_rs1_imag;
            end
            7'h2B: begin
               for (int i = 4; i > 0; i--) begin
                  x_re[i] <= x_re[i-1];
                  x_im[i] <= x_im[i-1];
               end
               x_re[0] <= scie_rs1_real;
               x_im[0] <= scie_rs1_imag;
            end
            7'h5B: begin
               scie_rd_real <= fir_out(1'b0);
               scie_rd_imag <= fir_out(1'b1);
            end
            default: ;
         endcase
      end
   end

   // Issue log and event counters, sampled mid-cycle.
   typedef struct {
      logic [31:0]        insn;
      logic [31:0]        rs2;
      logic signed [63:0] re;
      int                 cyc;
   } strobe_t;

   strobe_t log_q[$];
   int cyc = 0;
   int illegal_cnt = 0;
   int resp_cnt = 0;
   int idle_nonzero = 0;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (scie_valid) log_q.push_back('{scie_insn, scie_rs2, scie_rs1_real, cyc});
      else if (scie_insn != 0 || scie_rs1_real != 0 || scie_rs1_imag != 0 || scie_rs2 != 0)
         idle_nonzero++;
      if (illegal) illegal_cnt++;
      if (resp_valid) resp_cnt++;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic send(input logic [31:0] insn, input logic signed [63:0] re,
                       input logic signed [63:0] im, input logic [31:0] rs2,
                       input logic [4:0] tag, output bit ok);
      int waited = 0;
      in_valid = 1'b1; in_insn = insn; in_rs1_real = re; in_rs1_imag = im;
      in_rs2 = rs2; in_tag = tag;
      while (!in_ready && waited < 100) begin
         tick();
         waited++;
      end
      ok = in_ready;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_resp(output bit ok);
      int waited = 0;
      while (!resp_valid && waited < 200) begin
         tick();
         waited++;
      end
      ok = resp_valid;
   endtask

   task automatic wait_idle(output bit ok);
      int waited = 0;
      while (busy && waited < 200) begin
         tick();
         waited++;
      end
      ok = !busy;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in_insn = I_LOAD; resp_ready = 1'b1;
      repeat (2) tick();
      checks++; if (in_ready !== 1'b0)   $display("FAIL reset_in_ready: got %0b want 0", in_ready);     else passes++;
      checks++; if (scie_valid !== 1'b0) $display("FAIL reset_scie_valid: got %0b want 0", scie_valid); else passes++;
      checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %0b want 0", resp_valid); else passes++;
      checks++; if (illegal !== 1'b0)    $display("FAIL reset_illegal: got %0b want 0", illegal);       else passes++;
      checks++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %0b want 0", busy);             else passes++;
      in_valid = 1'b0; reset = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1)   $display("FAIL post_reset_in_ready: got %0b want 1", in_ready); else passes++;
      checks++; if (busy !== 1'b0)       $display("FAIL post_reset_busy: got %0b want 0", busy);         else passes++;
   endtask

   task automatic test_fir();
      bit ok, all_ok;
      int n0 = log_q.size();
      all_ok = 1'b1;
      resp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send(I_LOAD, COEF_RE[i], COEF_IM[i], i, 5'd0, ok);
         all_ok &= ok;
      end
      send(I_PUSH, 64'sd8438427473, -64'sd55890852234, 32'd0, 5'd0, ok);
      all_ok &= ok;
      send(I_READ, 64'sd0, 64'sd0, 32'd0, 5'd7, ok);
      all_ok &= ok;
      checks++; if (all_ok !== 1'b1) $display("FAIL fir_accept: got %0b want 1", all_ok); else passes++;
      wait_resp(ok);
      checks++; if (ok !== 1'b1) $display("FAIL fir_resp_timeout: got %0b want 1", ok); else passes++;
      checks++; if ($signed(resp_real) !== 64'sd672638403249)
         $display("FAIL fir_resp_real: got %0d want 672638403249", $signed(resp_real)); else passes++;
      checks++; if ($signed(resp_imag) !== -64'sd2611521281317)
         $display("FAIL fir_resp_imag: got %0d want -2611521281317", $signed(resp_imag)); else passes++;
      checks++; if (resp_tag !== 5'd7) $display("FAIL fir_resp_tag: got %0d want 7", resp_tag); else passes++;
      repeat (3) tick();
      checks++; if (resp_valid !== 1'b1 || $signed(resp_real) !== 64'sd672638403249)
         $display("FAIL fir_resp_hold: got valid=%0b real=%0d want 1/672638403249", resp_valid, $signed(resp_real));
      else passes++;
      resp_ready = 1'b1;
      tick();
      checks++; if (resp_valid !== 1'b0) $display("FAIL fir_resp_drop: got %0b want 0", resp_valid); else passes++;
      checks++; if (log_q.size() - n0 !== 7) $display("FAIL fir_issue_count: got %0d want 7", log_q.size() - n0); else passes++;
      if (log_q.size() - n0 >= 7) begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (log_q[n0+i].rs2 !== i || log_q[n0+i].re !== COEF_RE[i])
               $display("FAIL fir_load_order[%0d]: got rs2=%0d re=%0d want %0d/%0d", i, log_q[n0+i].rs2, log_q[n0+i].re, i, COEF_RE[i]);
            else passes++;
         end
         for (int i = 1; i < 5; i++) begin
            checks++; if (log_q[n0+i].cyc - log_q[n0+i-1].cyc !== 2)
               $display("FAIL load_spacing[%0d]: got %0d want 2", i, log_q[n0+i].cyc - log_q[n0+i-1].cyc);
            else passes++;
         end
      end
   endtask

   // PUSH dwells PUSH_GAP cycles in GAP, then one IDLE cycle precedes the next issue.
   task automatic test_push_gap();
      bit ok;
      int n0;
      wait_idle(ok);
      n0 = log_q.size();
      resp_ready = 1'b1;
      send(I_PUSH, 64'sd5, 64'sd6, 32'd0, 5'd0, ok);
      send(I_READ, 64'sd0, 64'sd0, 32'd0, 5'd2, ok);
      wait_resp(ok);
      checks++; if (ok !== 1'b1 || resp_tag !== 5'd2)
         $display("FAIL gap_resp: got ok=%0b tag=%0d want 1/2", ok, resp_tag); else passes++;
      tick();
      wait_idle(ok);
      checks++; if (log_q.size() - n0 !== 2) $display("FAIL gap_issue_count: got %0d want 2", log_q.size() - n0); else passes++;
      if (log_q.size() - n0 >= 2) begin
         checks++; if (log_q[n0].insn !== I_PUSH || log_q[n0+1].insn !== I_READ)
            $display("FAIL gap_order: got %0h,%0h want 2b,5b", log_q[n0].insn, log_q[n0+1].insn); else passes++;
         checks++; if (log_q[n0+1].cyc - log_q[n0].cyc !== PUSH_GAP + 2)
            $display("FAIL gap_spacing: got %0d want %0d", log_q[n0+1].cyc - log_q[n0].cyc, PUSH_GAP + 2);
         else passes++;
      end
   endtask

   task automatic test_illegal();
      bit ok;
      int n0, il0;
      wait_idle(ok);
      n0 = log_q.size();
      il0 = illegal_cnt;
      send(32'h0000_0033, 64'sd1, 64'sd2, 32'd3, 5'd4, ok);
      checks++; if (ok !== 1'b1) $display("FAIL illegal_accept: got %0b want 1", ok); else passes++;
      checks++; if (illegal !== 1'b1) $display("FAIL illegal_pulse: got %0b want 1", illegal); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL illegal_busy: got %0b want 0", busy); else passes++;
      tick();
      checks++; if (illegal !== 1'b0) $display("FAIL illegal_width: got %0b want 0", illegal); else passes++;
      repeat (3) tick();
      checks++; if (illegal_cnt - il0 !== 1) $display("FAIL illegal_count: got %0d want 1", illegal_cnt - il0); else passes++;
      checks++; if (log_q.size() !== n0) $display("FAIL illegal_no_issue: got %0d want %0d", log_q.size(), n0); else passes++;
   endtask

   task automatic test_back_to_back();
      bit ok, all_ok;
      int n0;
      wait_idle(ok);
      n0 = log_q.size();
      resp_ready = 1'b0;
      all_ok = 1'b1;
      send(I_READ, 64'sd0, 64'sd0, 32'd0, 5'd3, ok);
      wait_resp(ok);
      checks++; if (ok !== 1'b1 || resp_tag !== 5'd3)
         $display("FAIL full_pending_resp: got ok=%0b tag=%0d want 1/3", ok, resp_tag); else passes++;
      for (int i = 0; i < DEPTH; i++) begin
         send(I_LOAD, 64'sd100 + i, 64'sd0, 32'd10 + i, 5'd0, ok);
         all_ok &= ok;
      end
      checks++; if (all_ok !== 1'b1) $display("FAIL full_fill_accept: got %0b want 1", all_ok); else passes++;
      in_valid = 1'b1; in_insn = I_LOAD; in_rs2 = 32'd10 + DEPTH;
      checks++; if (in_ready !== 1'b0) $display("FAIL full_in_ready: got %0b want 0", in_ready); else passes++;
      repeat (2) tick();
      checks++; if (in_ready !== 1'b0 || resp_valid !== 1'b1)
         $display("FAIL full_hold: got ready=%0b resp=%0b want 0/1", in_ready, resp_valid); else passes++;
      checks++; if (log_q.size() - n0 !== 1) $display("FAIL full_no_issue: got %0d want 1", log_q.size() - n0); else passes++;
      resp_ready = 1'b1;
      send(I_LOAD, 64'sd100 + DEPTH, 64'sd0, 32'd10 + DEPTH, 5'd0, ok);
      checks++; if (ok !== 1'b1) $display("FAIL full_late_accept: got %0b want 1", ok); else passes++;
      wait_idle(ok);
      checks++; if (log_q.size() - n0 !== DEPTH + 2)
         $display("FAIL full_issue_count: got %0d want %0d", log_q.size() - n0, DEPTH + 2); else passes++;
      if (log_q.size() - n0 >= DEPTH + 2) begin
         for (int i = 0; i <= DEPTH; i++) begin
            checks++; if (log_q[n0+1+i].rs2 !== 32'd10 + i)
               $display("FAIL full_order[%0d]: got %0d want %0d", i, log_q[n0+1+i].rs2, 10 + i); else passes++;
         end
      end
   endtask

   task automatic test_reset_wait_rd();
      bit ok;
      int n0, r0, waited;
      wait_idle(ok);
      resp_ready = 1'b1;
      n0 = log_q.size();
      r0 = resp_cnt;
      send(I_READ, 64'sd0, 64'sd0, 32'd0, 5'd9, ok);
      waited = 0;
      while (log_q.size() == n0 && waited < 50) begin
         tick();
         waited++;
      end
      checks++; if (log_q.size() !== n0 + 1) $display("FAIL rst_read_issue: got %0d want %0d", log_q.size(), n0 + 1); else passes++;
      tick();
      checks++; if (busy !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL rst_in_wait_rd: got busy=%0b resp=%0b want 1/0", busy, resp_valid); else passes++;
      reset = 1'b1;
      tick();
      checks++; if ({scie_valid, resp_valid, illegal, busy, in_ready} !== 5'b0)
         $display("FAIL rst_flags: got %05b want 00000", {scie_valid, resp_valid, illegal, busy, in_ready}); else passes++;
      checks++; if (resp_real !== '0 || resp_imag !== '0 || resp_tag !== '0 || scie_insn !== '0 || scie_rs2 !== '0)
         $display("FAIL rst_data: got real=%0d tag=%0d insn=%0h want 0", resp_real, resp_tag, scie_insn); else passes++;
      reset = 1'b0;
      repeat (10) tick();
      checks++; if (resp_cnt !== r0) $display("FAIL rst_no_resp: got %0d want %0d", resp_cnt, r0); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL rst_idle_after: got %0b want 0", busy); else passes++;
   endtask

`ifdef SCIE_SEQ_PERF_EN
   task automatic test_perf();
      bit ok;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) send(I_LOAD, 64'sd1, 64'sd1, i, 5'd0, ok);
      wait_idle(ok);
      checks++; if (perf_issued !== 32'd3) $display("FAIL perf_issued: got %0d want 3", perf_issued); else passes++;
      checks++; if (perf_stall !== 32'd0) $display("FAIL perf_stall: got %0d want 0", perf_stall); else passes++;
   endtask
`endif

   task automatic test_idle_outputs();
      checks++; if (idle_nonzero !== 0) $display("FAIL idle_zero: got %0d nonzero cycles want 0", idle_nonzero); else passes++;
   endtask

   initial begin
      test_reset();
      test_fir();
      test_push_gap();
      test_illegal();
      test_back_to_back();
      test_reset_wait_rd();
`ifdef SCIE_SEQ_PERF_EN
      test_perf();
`endif
      test_idle_outputs();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
